// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg -- definitions shared by the program loader and the CPU.
//   LOADER_WIDTH / LOADER_ADDRESS_WIDTH : default data and RAM address widths.
//   loader_state_t                      : loader FSM state encoding.
// ST_CHECK only becomes reachable when LOADER_CHECKSUM_EN is defined. It is
// always listed here so that the encoding stays the same in every build.
package ram_loader_pkg;

    localparam int LOADER_WIDTH         = 8;
    localparam int LOADER_ADDRESS_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_ADDR,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if -- host handshake and RAM-side strobes of the program loader.
//   start, in_data, in_valid       : host -> loader
//   in_ready                       : loader -> host
//   ram_addr_enable, ram_write_enable, ram_bus : loader -> RAM
//   cpu_hold, done, error          : loader -> CPU / host status
// Modports: slave = loader side, master = host/system side.
interface ram_loader_if
    import ram_loader_pkg::*;
#(
    parameter int WIDTH = LOADER_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ram_addr_enable;
    logic             ram_write_enable;
    logic [WIDTH-1:0] ram_bus;
    logic             cpu_hold;
    logic             done;
    logic             error;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, ram_addr_enable, ram_write_enable, ram_bus,
               cpu_hold, done, error
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, ram_addr_enable, ram_write_enable, ram_bus,
               cpu_hold, done, error
    );
endinterface

// File: rtl/ram_loader_addr_counter.sv
// loader_addr_counter -- RAM write address counter for the loader.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : reset the count to 0 (clr has priority over inc)
//   inc        : advance by one; wraps to 0 after the last address
//   addr       : current address
//   last       : addr is the top address (2**ADDRESS_WIDTH-1)
module loader_addr_counter #(
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     last
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            addr <= '0;
        else if (clr)
            addr <= '0;
        else if (inc)
            addr <= addr + 1'b1;
    end

    assign last = &addr;
endmodule

// File: rtl/ram_loader.sv
// ram_loader -- streams host bytes into the CPU RAM and holds the CPU while
// it does so. For each byte the loader runs three cycles: it accepts the byte,
// then drives the address onto ram_bus with ram_addr_enable, then drives the
// byte onto ram_bus with ram_write_enable.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : ram_loader_if.slave (host handshake, RAM strobes, status)
// Optional macro LOADER_CHECKSUM_EN adds a trailing checksum byte. The
// checksum is the sum of all data bytes modulo 2**WIDTH. A mismatch sets
// error. When the macro is not defined, error is tied to 0.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int WIDTH         = LOADER_WIDTH,
    parameter int ADDRESS_WIDTH = LOADER_ADDRESS_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_loader_if.slave bus
);
    loader_state_t            state, state_nx;
    logic [WIDTH-1:0]         data_q;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     addr_last;
    logic                     start_ok;
    logic                     take;
    logic                     addr_inc;

    // start is honoured only between sessions.
    assign start_ok = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign take     = bus.in_valid && bus.in_ready;
    assign addr_inc = (state == ST_WRITE);

    loader_addr_counter #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_addr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_ok),
        .inc  (addr_inc),
        .addr (addr),
        .last (addr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (take && state == ST_ACCEPT)
                data_q <= bus.in_data;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;
    logic             err_q;

    // A handshake in ACCEPT carries a data byte and one in CHECK carries the
    // checksum byte. in_ready is low in every other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (start_ok) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (take) begin
            if (state == ST_ACCEPT)
                sum_q <= sum_q + bus.in_data;
            else
                err_q <= (bus.in_data != sum_q);
        end
    end

    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

    always_comb begin
        state_nx             = state;
        bus.in_ready         = 1'b0;
        bus.ram_addr_enable  = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.ram_bus          = '0;
        bus.cpu_hold         = 1'b0;
        bus.done             = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nx = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                bus.in_ready = 1'b1;
                bus.cpu_hold = 1'b1;
                if (bus.in_valid)
                    state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                bus.ram_addr_enable = 1'b1;
                bus.cpu_hold        = 1'b1;
                bus.ram_bus         = WIDTH'(addr);
                state_nx            = ST_WRITE;
            end
            ST_WRITE: begin
                bus.ram_write_enable = 1'b1;
                bus.cpu_hold         = 1'b1;
                bus.ram_bus          = data_q;
`ifdef LOADER_CHECKSUM_EN
                state_nx = addr_last ? ST_CHECK : ST_ACCEPT;
`else
                state_nx = addr_last ? ST_DONE : ST_ACCEPT;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                bus.in_ready = 1'b1;
                bus.cpu_hold = 1'b1;
                if (bus.in_valid)
                    state_nx = ST_DONE;
            end
`endif
            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.start)
                    state_nx = ST_ACCEPT;
            end
            default: state_nx = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader -- directed bench for ram_loader. A transaction-level model
// (a session phase plus a queue of pending RAM strobe events) predicts every
// output on every cycle. A RAM model built from the strobes is checked
// against literal contents. Add +define+LOADER_CHECKSUM_EN for the checksum
// build.
module tb_ram_loader;
    import ram_loader_pkg::*;

    localparam int W     = LOADER_WIDTH;
    localparam int AW    = LOADER_ADDRESS_WIDTH;
    localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_loader_if lif ();
    ram_loader dut (.clk(clk), .rst_n(rst_n), .bus(lif));

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int first_acc = -1;
    logic [W-1:0] q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // RAM model: address register loaded by mi, word written by ri.
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] mar;
    always @(posedge clk) begin
        if (lif.ram_addr_enable)  mar <= lif.ram_bus[AW-1:0];
        if (lif.ram_write_enable) mem[mar] <= lif.ram_bus;
    end

    // Behavioural model. phase: 0 idle, 1 taking data, 2 taking checksum, 3 done.
    typedef struct { bit is_wr; logic [W-1:0] val; } ev_t;
    ev_t          pend[$];
    int           m_phase = 0;
    int           m_idx   = 0;
    logic [W-1:0] m_sum   = '0;
    bit           m_err   = 1'b0;
    bit           armed   = 1'b0;

    always @(negedge clk) begin
        logic         e_ae, e_we, e_rdy, e_hold, e_done;
        logic [W-1:0] e_bus;
        ev_t          ev;
        e_ae = 0; e_we = 0; e_rdy = 0; e_hold = 0; e_done = 0; e_bus = '0;
        if (pend.size() > 0) begin
            e_hold = 1;
            e_bus  = pend[0].val;
            if (pend[0].is_wr) e_we = 1; else e_ae = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            e_rdy = 1; e_hold = 1;
        end else if (m_phase == 3) begin
            e_done = 1;
        end
        if (armed) begin
            chk("in_ready", lif.in_ready, e_rdy);
            chk("ram_addr_enable", lif.ram_addr_enable, e_ae);
            chk("ram_write_enable", lif.ram_write_enable, e_we);
            chk("ram_bus", lif.ram_bus, e_bus);
            chk("cpu_hold", lif.cpu_hold, e_hold);
            chk("done", lif.done, e_done);
            chk("error", lif.error, m_err);
        end
        // Advance to what the next posedge must produce.
        if (!rst_n) begin
            pend.delete(); m_phase = 0; m_idx = 0; m_sum = '0; m_err = 0; armed = 1;
        end else if (pend.size() > 0) begin
            ev = pend.pop_front();
            if (ev.is_wr) begin
                if (m_idx == DEPTH - 1) m_phase = CHK ? 2 : 3;
                m_idx = (m_idx + 1) % DEPTH;
            end
        end else if (m_phase == 1 && lif.in_valid) begin
            pend.push_back('{1'b0, W'(m_idx)});
            pend.push_back('{1'b1, lif.in_data});
            m_sum = m_sum + lif.in_data;
        end else if (m_phase == 2 && lif.in_valid) begin
            m_err   = (lif.in_data != m_sum);
            m_phase = 3;
        end else if ((m_phase == 0 || m_phase == 3) && lif.start) begin
            m_phase = 1; m_idx = 0; m_sum = '0; m_err = 0;
        end
    end

    // 16 data bytes base+k*step, then (checksum build) the checksum byte:
    // the true sum when bad_sum < 0, otherwise bad_sum.
    task automatic fill(input int base, input int step, input int bad_sum);
        logic [W-1:0] s;
        s = '0;
        q.delete();
        for (int k = 0; k < DEPTH; k++) begin
            q.push_back(W'(base + k * step));
            s = s + W'(base + k * step);
        end
        if (CHK) q.push_back(bad_sum < 0 ? s : W'(bad_sum));
    endtask

    task automatic pulse_start();
        lif.start = 1'b1;
        @(posedge clk); #1;
        lif.start = 1'b0;
    endtask

    // Offers q[k] until nbytes have been taken. If toggle is set, in_valid
    // alternates every cycle. start is pulsed once when k == start_at.
    task automatic session(input int nbytes, input bit toggle, input int start_at);
        int k = 0;
        int c = 0;
        bit v = 1'b1;
        bit acc;
        bit pulsed = 1'b0;
        while (k < nbytes && c < 400) begin
            lif.in_data  = q[k];
            lif.in_valid = toggle ? v : 1'b1;
            lif.start    = (k == start_at) && !pulsed;
            if (lif.start) pulsed = 1'b1;
            @(negedge clk);
            acc = lif.in_ready && lif.in_valid;
            if (acc && first_acc < 0) first_acc = cyc;
            @(posedge clk); #1;
            if (acc) k++;
            v = !v;
            c++;
        end
        lif.in_valid = 1'b0;
        lif.start    = 1'b0;
        chk("bytes_taken", k, nbytes);
    endtask

    task automatic wait_done(output int at);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!lif.done && c < 200);
        at = cyc;
        chk("done_reached", lif.done, 1'b1);
    endtask

    task automatic check_ram(input int base, input int step);
        for (int k = 0; k < DEPTH; k++)
            chk($sformatf("ram[%0d]", k), mem[k], W'(base + k * step));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int t;
        lif.start = 1'b0; lif.in_valid = 1'b0; lif.in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", lif.in_ready, 1'b0);
        chk("reset_cpu_hold", lif.cpu_hold, 1'b0);
        chk("reset_done", lif.done, 1'b0);
        chk("reset_ram_bus", lif.ram_bus, 8'h00);
        @(posedge clk); #1;

        // Constant in_valid: 0x10..0x1F, 48 cycles (+1 with checksum).
        fill(8'h10, 1, -1);
        pulse_start();
        first_acc = -1;
        session(q.size(), 1'b0, -1);
        wait_done(t);
        chk("done_latency", t - first_acc, CHK ? 49 : 48);
        chk("hold_after_done", lif.cpu_hold, 1'b0);
        check_ram(8'h10, 1);

        // Toggling in_valid: clear the RAM image through a new pattern first.
        fill(8'hA0, 1, -1);
        pulse_start(); session(q.size(), 1'b0, -1); wait_done(t);
        fill(8'h10, 1, -1);
        pulse_start(); session(q.size(), 1'b1, -1); wait_done(t);
        check_ram(8'h10, 1);

        // start during the session (after byte 3) must be ignored.
        fill(8'h20, 1, -1);
        pulse_start(); session(q.size(), 1'b0, 3); wait_done(t);
        check_ram(8'h20, 1);

`ifdef LOADER_CHECKSUM_EN
        fill(8'h01, 0, 8'h10);
        pulse_start(); session(q.size(), 1'b0, -1); wait_done(t);
        chk("csum_ok_error", lif.error, 1'b0);
        fill(8'h01, 0, 8'h11);
        pulse_start(); session(q.size(), 1'b0, -1); wait_done(t);
        chk("csum_bad_error", lif.error, 1'b1);
        check_ram(8'h01, 0);
`endif

        // start in DONE opens a new session with done/error cleared.
        fill(8'h50, 2, -1);
        pulse_start();
        chk("restart_done", lif.done, 1'b0);
        chk("restart_error", lif.error, 1'b0);
        chk("restart_ready", lif.in_ready, 1'b1);
        session(q.size(), 1'b0, -1); wait_done(t);
        check_ram(8'h50, 2);

        // Reset during the WRITE of the 5th byte, then reload from 0.
        fill(8'h30, 1, -1);
        pulse_start(); session(5, 1'b0, -1);
        @(posedge clk); #1;
        chk("pre_reset_write", lif.ram_write_enable, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_cpu_hold", lif.cpu_hold, 1'b0);
        chk("rst_ram_bus", lif.ram_bus, 8'h00);
        chk("rst_in_ready", lif.in_ready, 1'b0);
        chk("rst_ram_strobes", {lif.ram_addr_enable, lif.ram_write_enable}, 2'b00);
        chk("rst_partial_word4", mem[4], 8'h34);
        chk("rst_untouched_word5", mem[5], 8'h5A);
        fill(8'h40, 1, -1);
        pulse_start(); session(q.size(), 1'b0, -1); wait_done(t);
        check_ram(8'h40, 1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
